// File: rtl/alu_operand_stage.sv
// Operand fetch stage: 32-entry register file with writeback bypass feeding a
// one-deep valid/ready skid register that holds BusA/BusB/ALUCtrl for the ALU.
module alu_operand_stage #(
    parameter int n = 32
) (
    input  logic         Clk,
    input  logic         Reset_L,
    input  logic         InValid,
    output logic         InReady,
    input  logic [4:0]   RA,
    input  logic [4:0]   RB,
    input  logic         ImmSel,
    input  logic [n-1:0] Imm,
    input  logic [3:0]   ALUCtrlIn,
    input  logic [4:0]   RWIn,
    input  logic         RegWrIn,
    input  logic         WbEn,
    input  logic [4:0]   WbAddr,
    input  logic [n-1:0] WbData,
    output logic         OutValid,
    input  logic         OutReady,
    output logic [n-1:0] BusA,
    output logic [n-1:0] BusB,
    output logic [3:0]   ALUCtrl,
    output logic [4:0]   RWOut,
    output logic         RegWrOut
);

    logic [n-1:0] regs [32];
    logic [n-1:0] opa;
    logic [n-1:0] rb_val;
    logic [n-1:0] opb;
    logic         capture;

    // Entry 0 is never written; the read path forces it to zero anyway.
    always_ff @(posedge Clk or negedge Reset_L) begin
        if (!Reset_L) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (WbEn && (WbAddr != 5'd0)) begin
            regs[WbAddr] <= WbData;
        end
    end

    always_comb begin
        opa    = '0;
        rb_val = '0;
        if (RA != 5'd0) begin
            opa = (WbEn && (WbAddr == RA)) ? WbData : regs[RA];
        end
        if (RB != 5'd0) begin
            rb_val = (WbEn && (WbAddr == RB)) ? WbData : regs[RB];
        end
        opb = ImmSel ? Imm : rb_val;
    end

    assign InReady = !OutValid || OutReady;
    assign capture = InValid && InReady;

    // Operands are frozen once captured; only a new capture replaces them.
    always_ff @(posedge Clk or negedge Reset_L) begin
        if (!Reset_L) begin
            OutValid <= 1'b0;
            BusA     <= '0;
            BusB     <= '0;
            ALUCtrl  <= 4'b0000;
            RWOut    <= 5'd0;
            RegWrOut <= 1'b0;
        end else if (capture) begin
            OutValid <= 1'b1;
            BusA     <= opa;
            BusB     <= opb;
            ALUCtrl  <= ALUCtrlIn;
            RWOut    <= RWIn;
            RegWrOut <= RegWrIn;
        end else if (OutReady) begin
            OutValid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: behavioural reference model checked every
// cycle, plus literal expectations at the key points of the scenario.
module tb_alu_operand_stage;

    localparam int N = 32;

    logic         Clk = 1'b0;
    logic         Reset_L = 1'b0;
    logic         InValid = 1'b0;
    logic         InReady;
    logic [4:0]   RA = '0, RB = '0;
    logic         ImmSel = 1'b0;
    logic [N-1:0] Imm = '0;
    logic [3:0]   ALUCtrlIn = '0;
    logic [4:0]   RWIn = '0;
    logic         RegWrIn = 1'b0;
    logic         WbEn = 1'b0;
    logic [4:0]   WbAddr = '0;
    logic [N-1:0] WbData = '0;
    logic         OutValid;
    logic         OutReady = 1'b1;
    logic [N-1:0] BusA, BusB;
    logic [3:0]   ALUCtrl;
    logic [4:0]   RWOut;
    logic         RegWrOut;

    int n_checks = 0;
    int n_fail   = 0;

    alu_operand_stage #(.n(N)) dut (
        .Clk(Clk), .Reset_L(Reset_L), .InValid(InValid), .InReady(InReady),
        .RA(RA), .RB(RB), .ImmSel(ImmSel), .Imm(Imm), .ALUCtrlIn(ALUCtrlIn),
        .RWIn(RWIn), .RegWrIn(RegWrIn), .WbEn(WbEn), .WbAddr(WbAddr),
        .WbData(WbData), .OutValid(OutValid), .OutReady(OutReady),
        .BusA(BusA), .BusB(BusB), .ALUCtrl(ALUCtrl), .RWOut(RWOut),
        .RegWrOut(RegWrOut)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: architectural register contents plus the held instruction.
    logic [N-1:0] m_rf [32];
    logic         m_valid = 1'b0;
    logic [N-1:0] m_a = '0, m_b = '0;
    logic [3:0]   m_ctrl = '0;
    logic [4:0]   m_rw = '0;
    logic         m_regwr = 1'b0;

    initial for (int i = 0; i < 32; i++) m_rf[i] = '0;

    function automatic logic [N-1:0] m_read(input logic [4:0] a);
        if (a == 0) return '0;
        if (WbEn && WbAddr == a) return WbData;
        return m_rf[a];
    endfunction

    always @(negedge Reset_L) begin
        for (int i = 0; i < 32; i++) m_rf[i] = '0;
        m_valid = 0; m_a = '0; m_b = '0; m_ctrl = '0; m_rw = '0; m_regwr = 0;
    end

    always @(posedge Clk) begin
        if (Reset_L) begin
            if (InValid && (!m_valid || OutReady)) begin
                m_a     = m_read(RA);
                m_b     = ImmSel ? Imm : m_read(RB);
                m_ctrl  = ALUCtrlIn;
                m_rw    = RWIn;
                m_regwr = RegWrIn;
                m_valid = 1;
            end else if (OutReady) begin
                m_valid = 0;
            end
            if (WbEn && WbAddr != 0) m_rf[WbAddr] = WbData;
        end
    end

    always @(negedge Clk) begin
        if (Reset_L) begin
            check("in_ready",  InReady,  !m_valid || OutReady);
            check("out_valid", OutValid, m_valid);
            check("bus_a",     BusA,     m_a);
            check("bus_b",     BusB,     m_b);
            check("alu_ctrl",  ALUCtrl,  m_ctrl);
            check("rw_out",    RWOut,    m_rw);
            check("regwr_out", RegWrOut, m_regwr);
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        check("rst_valid", OutValid, 0);
        check("rst_bus_a", BusA, 0);
        check("rst_bus_b", BusB, 0);
        check("rst_ctrl",  ALUCtrl, 0);
        #11 Reset_L = 1'b1;
        tick();

        // Fill reg5 and reg6 through the writeback port.
        WbEn = 1; WbAddr = 5; WbData = 32'h0000_00F0;
        tick();
        WbAddr = 6; WbData = 32'h0000_0F0F;
        tick();
        WbEn = 0;
        InValid = 1; RA = 5; RB = 6; ImmSel = 0; ALUCtrlIn = 4'b0000; RWIn = 3; RegWrIn = 1;
        tick();
        check("basic_valid", OutValid, 1);
        check("basic_a", BusA, 32'h0000_00F0);
        check("basic_b", BusB, 32'h0000_0F0F);
        check("basic_ctrl", ALUCtrl, 4'b0000);

        // Same-cycle writeback bypass into operand A.
        RA = 7; RB = 5; ALUCtrlIn = 4'h2; RWIn = 9; RegWrIn = 0;
        WbEn = 1; WbAddr = 7; WbData = 32'h1234_5678;
        tick();
        check("bypass_a", BusA, 32'h1234_5678);
        check("bypass_b", BusB, 32'h0000_00F0);

        // Writes to register 0 are discarded, bypassed or not.
        InValid = 0; WbAddr = 0; WbData = 32'hFFFF_FFFF;
        tick();
        InValid = 1; RA = 0; RB = 0; ALUCtrlIn = 4'h3;
        tick();
        WbEn = 0;
        check("zero_a", BusA, 0);
        check("zero_b", BusB, 0);

        // Immediate select.
        RA = 6; RB = 6; ImmSel = 1; Imm = 32'hFFFF_FFFC; ALUCtrlIn = 4'h5;
        tick();
        check("imm_b", BusB, 32'hFFFF_FFFC);
        check("imm_a", BusA, 32'h0000_0F0F);

        // Stall with changing inputs and a writeback to a captured source.
        OutReady = 0; ImmSel = 0;
        WbEn = 1; WbAddr = 6; WbData = 32'hAAAA_AAAA;
        for (int i = 0; i < 3; i++) begin
            RA = (i == 0) ? 5'd5 : (i == 1) ? 5'd7 : 5'd1;
            ALUCtrlIn = 4'(8 + i);
            tick();
            WbEn = 0;
            check("stall_ready", InReady, 0);
            check("stall_a", BusA, 32'h0000_0F0F);
            check("stall_b", BusB, 32'hFFFF_FFFC);
            check("stall_ctrl", ALUCtrl, 4'h5);
        end

        // Release: drain and capture on the same edge.
        OutReady = 1; RA = 6; RB = 5; ALUCtrlIn = 4'h7;
        tick();
        check("thru_valid", OutValid, 1);
        check("thru_a", BusA, 32'hAAAA_AAAA);
        check("thru_b", BusB, 32'h0000_00F0);
        check("thru_ctrl", ALUCtrl, 4'h7);

        // Drain without a new instruction: operands hold.
        InValid = 0; RA = 5;
        tick();
        check("drain_valid", OutValid, 0);
        check("drain_a", BusA, 32'hAAAA_AAAA);
        tick();
        check("idle_a", BusA, 32'hAAAA_AAAA);

        // Reset between edges while stalled.
        InValid = 1; RA = 5; RB = 7; ALUCtrlIn = 4'h9;
        tick();
        OutReady = 0;
        tick();
        check("pre_rst_valid", OutValid, 1);
        #2 Reset_L = 0;
        #1;
        check("async_valid", OutValid, 0);
        check("async_a", BusA, 0);
        check("async_b", BusB, 0);
        check("async_ctrl", ALUCtrl, 0);
        check("async_ready", InReady, 1);
        WbEn = 1; WbAddr = 5; WbData = 32'h5555_5555;
        @(posedge Clk);
        #1;
        check("rst_hold_valid", OutValid, 0);
        check("rst_hold_a", BusA, 0);
        @(negedge Clk);
        #2;
        WbEn = 0; OutReady = 1;
        Reset_L = 1;
        tick();
        check("post_rst_valid", OutValid, 1);
        check("post_rst_a", BusA, 0);
        check("post_rst_b", BusB, 0);
        check("post_rst_ctrl", ALUCtrl, 4'h9);

        InValid = 0;
        tick();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
